// File: rtl/floor_request_scheduler_if.sv
// Button/service inputs and scheduler outputs between the scheduler and its
// neighbours in the elevator controller.
interface floor_request_scheduler_if #(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = 3
);
    localparam int CNT_W = $clog2(NUM_FLOORS + 1);

    logic [NUM_FLOORS-1:0] button_press;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] floor_request;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic                  sweep_up;
    logic [CNT_W-1:0]      pending_count;

    modport master (
        output button_press, current_floor, door_open,
        input  floor_request, target_floor, target_valid, sweep_up, pending_count
    );

    modport slave (
        input  button_press, current_floor, door_open,
        output floor_request, target_floor, target_valid, sweep_up, pending_count
    );
endinterface

// File: rtl/floor_request_scheduler.sv
// Pending-request capture for floors 0..NUM_FLOORS-1 and a SCAN scheduler
// that names the next floor to serve.
//
// state      | meaning
// IDLE       | no sweep in progress; serves here or picks a direction
// SWEEP_UP   | targets lowest pending floor at or above the car
// SWEEP_DOWN | targets highest pending floor at or below the car
module floor_request_scheduler #(
    parameter int NUM_FLOORS = 5,
    parameter int FLOOR_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    floor_request_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_FLOORS + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } state_t;

    state_t                state_q;
    logic [NUM_FLOORS-1:0] btn_prev_q;
    logic [NUM_FLOORS-1:0] req_q, req_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FLOOR_W-1:0]    target_q;
    logic                  valid_q;
    logic                  sweep_up_q;

    logic [NUM_FLOORS-1:0] set_w, clr_w;
    logic                  here, above, below;
    logic                  up_found, dn_found;
    logic [FLOOR_W-1:0]    up_idx, dn_idx;
    logic [FLOOR_W-1:0]    dist_up, dist_dn;

    // An out-of-range floor matches no bit, so it never clears anything.
    always_comb begin
        set_w = bus.button_press & ~btn_prev_q;
        clr_w = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clr_w[i] = bus.door_open && (bus.current_floor == FLOOR_W'(i));
        end
        req_d = (req_q | set_w) & ~clr_w;
        cnt_d = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            cnt_d = cnt_d + CNT_W'(req_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_prev_q <= '0;
            req_q      <= '0;
            cnt_q      <= '0;
        end else begin
            btn_prev_q <= bus.button_press;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
        end
    end

    // Descending scan leaves the lowest match, ascending scan the highest.
    always_comb begin
        here     = 1'b0;
        above    = 1'b0;
        below    = 1'b0;
        up_found = 1'b0;
        dn_found = 1'b0;
        up_idx   = '0;
        dn_idx   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (req_q[i] && (FLOOR_W'(i) >= bus.current_floor)) begin
                up_found = 1'b1;
                up_idx   = FLOOR_W'(i);
            end
            if (req_q[i] && (FLOOR_W'(i) > bus.current_floor)) begin
                above = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req_q[i] && (FLOOR_W'(i) <= bus.current_floor)) begin
                dn_found = 1'b1;
                dn_idx   = FLOOR_W'(i);
            end
            if (req_q[i] && (FLOOR_W'(i) < bus.current_floor)) begin
                below = 1'b1;
            end
            if (req_q[i] && (FLOOR_W'(i) == bus.current_floor)) begin
                here = 1'b1;
            end
        end
        // Only consulted when nothing is pending here, so up_idx/dn_idx are
        // the nearest floors strictly above/below.
        dist_up = up_idx - bus.current_floor;
        dist_dn = bus.current_floor - dn_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            target_q   <= '0;
            valid_q    <= 1'b0;
            sweep_up_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (here) begin
                        target_q <= bus.current_floor;
                        valid_q  <= 1'b1;
                    end else if (above && (!below || (dist_up <= dist_dn))) begin
                        state_q    <= SWEEP_UP;
                        sweep_up_q <= 1'b1;
                        target_q   <= up_idx;
                        valid_q    <= 1'b1;
                    end else if (below) begin
                        state_q    <= SWEEP_DOWN;
                        sweep_up_q <= 1'b0;
                        target_q   <= dn_idx;
                        valid_q    <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                SWEEP_UP: begin
                    if (up_found) begin
                        target_q <= up_idx;
                        valid_q  <= 1'b1;
                    end else if (below) begin
                        state_q    <= SWEEP_DOWN;
                        sweep_up_q <= 1'b0;
                        target_q   <= dn_idx;
                        valid_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                SWEEP_DOWN: begin
                    if (dn_found) begin
                        target_q <= dn_idx;
                        valid_q  <= 1'b1;
                    end else if (above) begin
                        state_q    <= SWEEP_UP;
                        sweep_up_q <= 1'b1;
                        target_q   <= up_idx;
                        valid_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.floor_request = req_q;
    assign bus.pending_count = cnt_q;
    assign bus.target_floor  = target_q;
    assign bus.target_valid  = valid_q;
    assign bus.sweep_up      = sweep_up_q;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler; expected outputs are queued
// when stimulus is applied and compared after the clock edge.
module tb_floor_request_scheduler;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    floor_request_scheduler_if bus ();

    floor_request_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [4:0] fr;
        logic [2:0] tf;
        logic       tv;
        logic       su;
        logic [2:0] pc;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input string tag, input logic [4:0] fr, input logic [2:0] tf,
                            input logic tv, input logic su, input logic [2:0] pc);
        exp_t e;
        e.tag = tag; e.fr = fr; e.tf = tf; e.tv = tv; e.su = su; e.pc = pc;
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        checks++;
        assert ({bus.floor_request, bus.target_floor, bus.target_valid, bus.sweep_up, bus.pending_count}
                === {e.fr, e.tf, e.tv, e.su, e.pc})
        else begin
            errors++;
            $error("FAIL %s observed fr=%b tf=%0d tv=%b su=%b pc=%0d expected fr=%b tf=%0d tv=%b su=%b pc=%0d",
                   e.tag, bus.floor_request, bus.target_floor, bus.target_valid, bus.sweep_up,
                   bus.pending_count, e.fr, e.tf, e.tv, e.su, e.pc);
        end
    endtask

    task automatic step(input string tag, input logic [4:0] fr, input logic [2:0] tf,
                        input logic tv, input logic su, input logic [2:0] pc);
        push_exp(tag, fr, tf, tv, su, pc);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic now_check(input string tag, input logic [4:0] fr, input logic [2:0] tf,
                             input logic tv, input logic su, input logic [2:0] pc);
        push_exp(tag, fr, tf, tv, su, pc);
        compare_out();
    endtask

    initial begin
        reset = 1'b0;
        bus.button_press  = 5'b11111;
        bus.current_floor = 3'd0;
        bus.door_open     = 1'b0;
        #12;
        now_check("rst_hold", 5'b00000, 3'd0, 1'b0, 1'b1, 3'd0);
        reset = 1'b1;
        step("rst_release", 5'b11111, 3'd0, 1'b0, 1'b1, 3'd5);

        // Async reset between edges, then a single up request from floor 0
        reset = 1'b0;
        bus.button_press = 5'b00000;
        #1;
        now_check("rst_async", 5'b00000, 3'd0, 1'b0, 1'b1, 3'd0);
        reset = 1'b1;
        bus.button_press = 5'b01000;
        step("up_press", 5'b01000, 3'd0, 1'b0, 1'b1, 3'd1);
        bus.button_press = 5'b00000;
        step("up_target", 5'b01000, 3'd3, 1'b1, 1'b1, 3'd1);
        bus.current_floor = 3'd3;
        bus.door_open     = 1'b1;
        step("up_serve", 5'b00000, 3'd3, 1'b1, 1'b1, 3'd0);
        step("up_idle", 5'b00000, 3'd3, 1'b0, 1'b1, 3'd0);
        bus.door_open = 1'b0;

        // SCAN ordering from floor 2 going up with 4, 1, 0 pending
        bus.current_floor = 3'd2;
        bus.button_press  = 5'b10000;
        step("scan_p4", 5'b10000, 3'd3, 1'b0, 1'b1, 3'd1);
        bus.button_press = 5'b00011;
        step("scan_p01", 5'b10011, 3'd4, 1'b1, 1'b1, 3'd3);
        bus.button_press = 5'b00000;
        step("scan_up", 5'b10011, 3'd4, 1'b1, 1'b1, 3'd3);
        bus.current_floor = 3'd4;
        bus.door_open     = 1'b1;
        step("scan_srv4", 5'b00011, 3'd4, 1'b1, 1'b1, 3'd2);
        bus.door_open = 1'b0;
        step("scan_rev", 5'b00011, 3'd1, 1'b1, 1'b0, 3'd2);
        bus.current_floor = 3'd1;
        bus.door_open     = 1'b1;
        step("scan_srv1", 5'b00001, 3'd1, 1'b1, 1'b0, 3'd1);
        bus.door_open = 1'b0;
        step("scan_t0", 5'b00001, 3'd0, 1'b1, 1'b0, 3'd1);
        bus.current_floor = 3'd0;
        bus.door_open     = 1'b1;
        step("scan_srv0", 5'b00000, 3'd0, 1'b1, 1'b0, 3'd0);
        bus.door_open = 1'b0;
        step("scan_done", 5'b00000, 3'd0, 1'b0, 1'b0, 3'd0);

        // Held button: one request only, served while still held
        bus.button_press = 5'b10000;
        step("hold_set", 5'b10000, 3'd0, 1'b0, 1'b0, 3'd1);
        step("hold_up", 5'b10000, 3'd4, 1'b1, 1'b1, 3'd1);
        bus.current_floor = 3'd4;
        bus.door_open     = 1'b1;
        step("hold_srv", 5'b00000, 3'd4, 1'b1, 1'b1, 3'd0);
        bus.door_open = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step("hold_keep", 5'b00000, 3'd4, 1'b0, 1'b1, 3'd0);
        end
        bus.button_press = 5'b00000;
        step("hold_rel", 5'b00000, 3'd4, 1'b0, 1'b1, 3'd0);
        bus.button_press = 5'b10000;
        step("hold_repress", 5'b10000, 3'd4, 1'b0, 1'b1, 3'd1);
        bus.button_press = 5'b00000;
        bus.door_open    = 1'b1;
        step("hold_here", 5'b00000, 3'd4, 1'b1, 1'b1, 3'd0);
        bus.door_open = 1'b0;
        step("hold_done", 5'b00000, 3'd4, 1'b0, 1'b1, 3'd0);

        // Press at the open-door floor is dropped; floor 3 is kept
        bus.current_floor = 3'd1;
        bus.door_open     = 1'b1;
        bus.button_press  = 5'b01010;
        step("setclr", 5'b01000, 3'd4, 1'b0, 1'b1, 3'd1);
        bus.button_press = 5'b00000;
        bus.door_open    = 1'b0;
        step("setclr_tgt", 5'b01000, 3'd3, 1'b1, 1'b1, 3'd1);

        // Out-of-range floor: no clearing, everything counts as below
        bus.current_floor = 3'd6;
        bus.door_open     = 1'b1;
        step("oor", 5'b01000, 3'd3, 1'b1, 1'b0, 3'd1);
        bus.current_floor = 3'd3;
        step("oor_clr", 5'b00000, 3'd3, 1'b1, 1'b0, 3'd0);
        bus.door_open = 1'b0;
        step("oor_idle", 5'b00000, 3'd3, 1'b0, 1'b0, 3'd0);

        // Equidistant tie from IDLE goes up, then reset mid-sweep
        bus.current_floor = 3'd2;
        bus.button_press  = 5'b10001;
        step("tie_press", 5'b10001, 3'd3, 1'b0, 1'b0, 3'd2);
        bus.button_press = 5'b00000;
        step("tie_up", 5'b10001, 3'd4, 1'b1, 1'b1, 3'd2);
        #3;
        reset = 1'b0;
        #1;
        now_check("rst_mid", 5'b00000, 3'd0, 1'b0, 1'b1, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
- Upstream stage of elevator_controller.
- Captures cabin/hall button presses for floors 0-4 and holds them as a pending-request mask.
- Clears each request when the controller serves that floor.
- Runs a SCAN (up-sweep/down-sweep) scheduler that names the next target floor; the pending mask drives elevator_controller.floor_request directly.

Parameters:
- NUM_FLOORS, 5, number of floors; the mask width equals NUM_FLOORS. Only the value 5 is verified.
- FLOOR_W, 3, width of floor-index fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous reset, active-low: asserted when 0, released when 1.
- button_press  input  5  raw button levels, already synchronous to clk; bit i = floor i.
- current_floor  input  3  floor index from elevator_controller.
- door_open  input  1  from elevator_controller; high while the door is open at current_floor.
- floor_request  output  5  registered pending-request mask, fed to elevator_controller.
- target_floor  output  3  registered next floor to serve.
- target_valid  output  1  high when target_floor is meaningful.
- sweep_up  output  1  current sweep direction: 1 = up, 0 = down.
- pending_count  output  3  popcount of floor_request, range 0..5.

Behaviour:
- Reset (reset==0, asynchronous, immediate, including mid-sweep):
  - floor_request=0, target_floor=0, target_valid=0, sweep_up=1, pending_count=0.
  - Button-history register=0.
  - State = IDLE.
- Press capture:
  - The block registers btn_prev <= button_press every cycle.
  - set[i] = button_press[i] & ~btn_prev[i] (rising-edge detect).
  - A held button produces exactly one request; it must be released and pressed again to re-request.
  - A button already high on the first edge after reset release counts as a new press, because btn_prev is 0 after reset.
- Service clear: clr[i] = door_open & (current_floor==i). If current_floor>4, clr=0 for every bit.
- Pending update each edge: floor_request <= (floor_request | set) & ~clr.
  - Clear wins when set and clear hit the same bit in the same cycle: a press at the floor with the door open is dropped, being served already.
- Latency:
  - A press sampled at edge k appears in floor_request after edge k.
  - The press is reflected in target_floor/target_valid after edge k+1.
- pending_count is registered and computed from the next-state mask, so it is always consistent with floor_request in the same cycle.
- Scheduler FSM: states IDLE, SWEEP_UP, SWEEP_DOWN. It is evaluated each edge using the registered floor_request and current_floor.
  - Definitions:
    - above = any pending bit with index > current_floor.
    - below = any pending bit with index < current_floor.
    - here = the pending bit at current_floor.
  - IDLE:
    - If here: target=current_floor, valid=1, stay IDLE.
    - Else if above and below: go to the sweep whose nearest pending floor is closer. On a tie, go SWEEP_UP.
    - Else if above only: go SWEEP_UP. Else if below only: go SWEEP_DOWN.
    - Else: valid=0, hold target_floor.
  - SWEEP_UP (sweep_up=1):
    - target = lowest pending index >= current_floor.
    - If none: go SWEEP_DOWN if below, else go IDLE with valid=0.
  - SWEEP_DOWN (sweep_up=0):
    - target = highest pending index <= current_floor.
    - If none: go SWEEP_UP if above, else go IDLE with valid=0.
  - A direction change updates target in the same edge as the state change, so the target never points backwards within a sweep.
  - sweep_up holds its last value in IDLE.
- Out-of-range current_floor (5-7):
  - Treated as above every floor, so every pending bit counts as below.
  - No clearing occurs.
  - The FSM must never output target_floor>4.
- New requests arriving mid-sweep:
  - A request ahead of the car in the current direction is picked up on the next target evaluation.
  - A request behind the car waits for the reverse sweep.

Test Plan:
- Reset: hold reset=0 with button_press=5'b11111 -> all outputs 0, sweep_up=1. Release reset, keep buttons held -> floor_request=5'b11111 one edge later, pending_count=5.
- Single up request: current_floor=0, pulse button_press=5'b01000 for one cycle -> floor_request=5'b01000 after edge k, target_floor=3, target_valid=1, sweep_up=1 after edge k+1. Then set current_floor=3, door_open=1 -> floor_request=0, then target_valid=0, state IDLE.
- SCAN ordering: current_floor=2, sweep_up=1, pending 5'b10011 -> target 4. After floor 4 is cleared -> sweep_up=0, target 1. After floor 1 is cleared -> target 0. After floor 0 is cleared -> target_valid=0.
- Held button: keep button_press[4]=1 for 20 cycles, serve floor 4 at cycle 5 -> bit 4 clears and does not re-set while held. Release and press again -> bit 4 sets again.
- Simultaneous set and clear: current_floor=1, door_open=1, rising edge on button_press[1] in the same cycle -> floor_request[1] stays 0. In the same cycle, button_press[3] rises -> floor_request=5'b01000.
- Equidistant tie from IDLE: current_floor=2, pending 5'b10001 -> SWEEP_UP, target 4. Assert reset mid-sweep -> all outputs 0 immediately, without waiting for a clock.
